// File: rtl/lcd_status_writer_if.sv
// Byte-transfer handshake between the status writer and an HD44780-style LCD controller.
// The writer presents a byte plus register select and raises start; the controller answers with done.
interface lcd_status_writer_if;
  logic [7:0] oDATA;
  logic       oRS;
  logic       oSTART;
  logic       iDONE;

  modport master (output oDATA, output oRS, output oSTART, input iDONE);
  modport slave  (input oDATA, input oRS, input oSTART, output iDONE);
endinterface

// File: rtl/lcd_status_writer.sv
// Drives a 16x2 character LCD with the elevator mode (line 1) and floor number (line 2),
// running the init commands once after reset and re-drawing the screen whenever the inputs change.
module lcd_status_writer #(
  parameter int DLY_CYCLES = 262142,
  parameter int FLOOR_W    = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [1:0]         iMODE,
  input  logic [FLOOR_W-1:0] iFLOOR,
  lcd_status_writer_if.master lcd,
  output logic               oBUSY,
  output logic               oREADY
);

  localparam int CNT_W = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY_CYCLES - 1);

  // Entry map: 0..3 init commands, 4 line-1 address, 5..20 line-1 text,
  // 21 line-2 address, 22..37 line-2 text.
  localparam logic [5:0] IDX_INIT_LAST = 6'd3;
  localparam logic [5:0] IDX_REFRESH   = 6'd4;
  localparam logic [5:0] IDX_L1        = 6'd5;
  localparam logic [5:0] IDX_CMD2      = 6'd21;
  localparam logic [5:0] IDX_L2        = 6'd22;
  localparam logic [5:0] IDX_LAST      = 6'd37;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, DELAY, NEXT} state_t;

  state_t             r_state;
  logic [5:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_snap_mode;
  logic [FLOOR_W-1:0] r_snap_floor;
  logic               r_pending;
  logic               r_busy;
  logic               r_ready;
  logic               r_start;
  logic               r_rs;
  logic [7:0]         r_data;

  logic [7:0]         w_entry_data;
  logic               w_entry_rs;
  logic               w_changed;

  function automatic logic [7:0] line1_char(input logic [1:0] mode, input logic [3:0] pos);
    logic [127:0] s;
    logic [127:0] sh;
    case (mode)
      2'd0:    s = {"Parado",     {10{8'h20}}};
      2'd1:    s = {"Subindo +",  {7{8'h20}}};
      2'd2:    s = {"Descendo -", {6{8'h20}}};
      default: s = {"Erro",       {12{8'h20}}};
    endcase
    sh = s << {pos, 3'b000};
    return sh[127:120];
  endfunction

  // Floors above 99 do not fit two digits, so both positions show a dash.
  function automatic logic [7:0] line2_char(input logic [6:0] floor, input logic [3:0] pos);
    logic [7:0]   tens;
    logic [7:0]   ones;
    logic [127:0] s;
    logic [127:0] sh;
    if (floor > 7'd99) begin
      tens = 8'h2D;
      ones = 8'h2D;
    end else begin
      tens = 8'h30 + 8'(floor / 7'd10);
      ones = 8'h30 + 8'(floor % 7'd10);
    end
    s  = {"Andar ", tens, ones, {8{8'h20}}};
    sh = s << {pos, 3'b000};
    return sh[127:120];
  endfunction

  assign w_changed = (iMODE != r_snap_mode) || (iFLOOR != r_snap_floor);

  always_comb begin
    w_entry_data = 8'h00;
    w_entry_rs   = 1'b0;
    if (r_idx < IDX_REFRESH) begin
      case (r_idx[1:0])
        2'd0:    w_entry_data = 8'h38;
        2'd1:    w_entry_data = 8'h0C;
        2'd2:    w_entry_data = 8'h01;
        default: w_entry_data = 8'h06;
      endcase
    end else if (r_idx == IDX_REFRESH) begin
      w_entry_data = 8'h80;
    end else if (r_idx < IDX_CMD2) begin
      w_entry_rs   = 1'b1;
      w_entry_data = line1_char(r_snap_mode, 4'(r_idx - IDX_L1));
    end else if (r_idx == IDX_CMD2) begin
      w_entry_data = 8'hC0;
    end else begin
      w_entry_rs   = 1'b1;
      w_entry_data = line2_char(7'(r_snap_floor), 4'(r_idx - IDX_L2));
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= LOAD;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_snap_mode  <= '0;
      r_snap_floor <= '0;
      r_pending    <= 1'b0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
      r_start      <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
    end else begin
      r_busy <= 1'b1;
      // Any change seen mid-sequence is remembered; every refresh start clears it below.
      if (w_changed) r_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          r_busy    <= w_changed;
          r_pending <= 1'b0;
          if (w_changed) begin
            r_snap_mode  <= iMODE;
            r_snap_floor <= iFLOOR;
            r_idx        <= IDX_REFRESH;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_data  <= w_entry_data;
          r_rs    <= w_entry_rs;
          r_start <= 1'b1;
          r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (lcd.iDONE) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= DELAY;
          end
        end
        DELAY: begin
          if (r_cnt == CNT_LAST) r_state <= NEXT;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        NEXT: begin
          if (r_idx == IDX_LAST) begin
            r_ready <= 1'b1;
            if (r_pending || w_changed) begin
              r_snap_mode  <= iMODE;
              r_snap_floor <= iFLOOR;
              r_pending    <= 1'b0;
              r_idx        <= IDX_REFRESH;
              r_state      <= LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            // Leaving the init block starts the first refresh, so take the snapshot here.
            if (r_idx == IDX_INIT_LAST) begin
              r_snap_mode  <= iMODE;
              r_snap_floor <= iFLOOR;
              r_pending    <= 1'b0;
            end
            r_idx   <= r_idx + 6'd1;
            r_state <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign lcd.oDATA  = r_data;
  assign lcd.oRS    = r_rs;
  assign lcd.oSTART = r_start;
  assign oBUSY      = r_busy;
  assign oREADY     = r_ready;

endmodule
